// File: rtl/bsreg_beh_pkg.sv
// Shared constants for the bidirectional shift register.
package bsreg_beh_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/bsreg_beh.sv
// Bidirectional serial-in, parallel-out shift register; shifts on every clk edge.
// Latency: 1 cycle (register update); no backpressure, no hold state.
module bsreg_beh
  import bsreg_beh_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] shift_nxt;

  // Only an explicit 1 selects left; X/Z or 0 fall through to shift right.
  always_comb begin
    shift_nxt = {serial_in, data_out[WIDTH-1:1]};
    if (dir == DIR_LEFT) begin
      shift_nxt = {data_out[WIDTH-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      data_out <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_bsreg_beh.sv
// Directed-vector bench for bsreg_beh at WIDTH=4 and WIDTH=8.
module tb_bsreg_beh;

  logic       clk = 1'b0;
  logic       rst;
  logic       dir;
  logic       serial_in;
  logic [3:0] data_out;
  logic       dir8;
  logic       serial_in8;
  logic [7:0] data_out8;

  int checks = 0;
  int errors = 0;

  bsreg_beh #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .dir       (dir),
    .serial_in (serial_in),
    .data_out  (data_out)
  );

  bsreg_beh #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .dir       (dir8),
    .serial_in (serial_in8),
    .data_out  (data_out8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, take one edge, sample 1 time unit after it.
  task automatic step4(input logic d, input logic s, input logic [3:0] e, input string tag);
    dir = d;
    serial_in = s;
    @(posedge clk);
    #1;
    chk(tag, {4'b0, data_out}, {4'b0, e});
  endtask

  task automatic step8(input logic d, input logic s, input logic [7:0] e, input string tag);
    dir8 = d;
    serial_in8 = s;
    @(posedge clk);
    #1;
    chk(tag, data_out8, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_imm4", {4'b0, data_out}, 8'h00);
    chk("rst_imm8", data_out8, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release", {4'b0, data_out}, 8'h00);
  endtask

  logic [7:0] fill8 [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

  initial begin
    rst = 1'b1;
    dir = 1'b0;
    serial_in = 1'b0;
    dir8 = 1'b0;
    serial_in8 = 1'b0;
    #1;
    chk("rst_initial", {4'b0, data_out}, 8'h00);

    // Reset held across edges, even with serial_in=1 presented.
    serial_in = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_held", {4'b0, data_out}, 8'h00);
    end

    // Load a nonzero value, then assert reset asynchronously mid-cycle.
    @(negedge clk);
    rst = 1'b0;
    step4(1'b0, 1'b1, 4'b1000, "load");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {4'b0, data_out}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hold_after_release", {4'b0, data_out}, 8'h00);

    // Right fill, then direction switch.
    step4(1'b0, 1'b1, 4'b1000, "right_fill_0");
    step4(1'b0, 1'b0, 4'b0100, "right_fill_1");
    step4(1'b0, 1'b1, 4'b1010, "right_fill_2");
    step4(1'b1, 1'b1, 4'b0101, "dir_switch_0");
    step4(1'b1, 1'b0, 4'b1010, "dir_switch_1");

    // Left fill from reset, with MSB ejection.
    do_reset();
    step4(1'b1, 1'b1, 4'b0001, "left_fill_0");
    step4(1'b1, 1'b1, 4'b0011, "left_fill_1");
    step4(1'b1, 1'b0, 4'b0110, "left_fill_2");
    step4(1'b1, 1'b1, 4'b1101, "left_fill_3");
    step4(1'b1, 1'b0, 4'b1010, "left_eject");

    // Fill with ones, then drain zeros through from the MSB.
    do_reset();
    step4(1'b0, 1'b1, 4'b1000, "ones_0");
    step4(1'b0, 1'b1, 4'b1100, "ones_1");
    step4(1'b0, 1'b1, 4'b1110, "ones_2");
    step4(1'b0, 1'b1, 4'b1111, "ones_3");
    step4(1'b0, 1'b0, 4'b0111, "drain_0");
    step4(1'b0, 1'b0, 4'b0011, "drain_1");
    step4(1'b0, 1'b0, 4'b0001, "drain_2");
    step4(1'b0, 1'b0, 4'b0000, "drain_3");

    // Wide instance.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step8(1'b0, 1'b1, fill8[i], $sformatf("w8_fill_%0d", i));
    end
    step8(1'b1, 1'b0, 8'hFE, "w8_left");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
